mdu_iter: RTL and testbench

//  Iterative multiply/divide unit for the multicycle MIPS core. Executes MULT/MULTU/DIV/DIVU.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/flopenr.sv | 20 ++
 rtl/flopr.sv | 20 ++
 rtl/mdu_fsm.sv | 71 +++++++
 rtl/mdu_iter.sv | 147 ++++++++++++++
 tb/tb_mdu_iter.sv | 205 ++++++++++++++++++++
 6 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the iterative multiply/divide unit.
//   mdu_op_t    operation encoding as driven by the controller on op[1:0]
//   mdu_state_t sequencer states
//   MDU_WIDTH   default operand width, MDU_LATENCY start-edge to HI/LO-valid edges
package mdu_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_t;

    localparam int MDU_WIDTH   = 32;
    localparam int MDU_LATENCY = MDU_WIDTH + 1;

endpackage

// File: rtl/flopenr.sv
// flopenr: register with load enable and asynchronous active-high reset to zero.
//   clk, reset  clock / async reset
//   en          load d at the rising edge when high, hold otherwise
//   d, q        WIDTH-bit data in / registered out
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/flopr.sv
// flopr: plain register with asynchronous active-high reset to zero.
//   clk, reset  clock / async reset
//   d, q        WIDTH-bit data in / registered out
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its input from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/mdu_fsm.sv
// mdu_fsm: sequencer for the iterative MDU (IDLE -> RUN -> FIN -> IDLE).
//   clk, reset  clock / async active-high reset
//   start       launch request, honoured only in IDLE
//   accept      comb: operands are captured at this edge (E0)
//   run         comb: datapath performs one iteration at this edge
//   fin         comb: HI/LO are written at this edge
//   busy        registered: an op is in flight
//   done        registered: one-cycle pulse after HI/LO update
module mdu_fsm
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic accept,
    output logic run,
    output logic fin,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_d, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every signal written here is given a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        count_d = '0;
        accept  = 1'b0;
        run     = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run     = 1'b1;
                // Counter wraps to zero on the last iteration edge.
                count_d = count_q + CW'(1);
                if (count_q == LAST) state_d = FIN;
            end
            FIN: begin
                fin     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = fin;
    end

    flopr #(.WIDTH(CW)) u_count (.clk(clk), .reset(reset), .d(count_d), .q(count_q));
    flopr #(.WIDTH(1))  u_busy  (.clk(clk), .reset(reset), .d(busy_d),  .q(busy));
    flopr #(.WIDTH(1))  u_done  (.clk(clk), .reset(reset), .d(done_d),  .q(done));

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit (MULT/MULTU/DIV/DIVU), one
// iteration per clock, WIDTH iterations per op, HI/LO written on the
// following edge.
//   clk, reset  clock / async active-high reset (aborts any op in flight)
//   start, op   launch request and operation (mdu_op_t encoding)
//   a, b        multiplicand/dividend, multiplier/divisor
//   busy, done  op in flight / one-cycle pulse after HI/LO update
//   hi, lo      product upper/lower, or remainder/quotient
// Build option: define MDU_DIV_EN to build the divider datapath. Without
// it DIV/DIVU keep full busy/done timing but leave HI/LO untouched.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic accept, run, fin;

    mdu_fsm #(.WIDTH(WIDTH)) u_fsm (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .accept (accept),
        .run    (run),
        .fin    (fin),
        .busy   (busy),
        .done   (done)
    );

    // ---------------- operand capture (E0) ----------------
    logic             is_signed, a_neg, b_neg, is_div_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             is_div_q, neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;

    always_comb begin
        is_signed = (op == MULT) || (op == DIV);
        is_div_in = op[1];
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
        // Product/quotient sign. A zero divisor must leave the all-ones
        // quotient unfixed, so its sign is forced positive.
        neg_lo_d  = (a_neg ^ b_neg) & ~(is_div_in & (b == '0));
        // Multiply keeps the multiplicand here; divide keeps |b|.
        opnd_d    = is_div_in ? mag_b : mag_a;
    end

    flopenr #(.WIDTH(1))     u_is_div (.clk(clk), .reset(reset), .en(accept), .d(is_div_in), .q(is_div_q));
    flopenr #(.WIDTH(1))     u_neg_lo (.clk(clk), .reset(reset), .en(accept), .d(neg_lo_d),  .q(neg_lo_q));
    flopenr #(.WIDTH(WIDTH)) u_opnd   (.clk(clk), .reset(reset), .en(accept), .d(opnd_d),    .q(opnd_q));

`ifdef MDU_DIV_EN
    // Remainder takes the dividend's sign; a raw negative dividend
    // under divide-by-zero is restored by the same negation.
    logic neg_hi_q;
    flopenr #(.WIDTH(1)) u_neg_hi (.clk(clk), .reset(reset), .en(accept), .d(a_neg), .q(neg_hi_q));
`endif

    // ---------------- iteration datapath ----------------
    // acc_q: WIDTH+1-bit accumulator (multiply) or partial remainder (divide).
    // sr_q : multiplier shifting out right (multiply), or dividend shifting
    //        out left while quotient bits shift in (divide).
    logic [WIDTH:0]   acc_q, acc_d, mul_sum;
    logic [WIDTH-1:0] sr_q, sr_d;
`ifdef MDU_DIV_EN
    logic [WIDTH:0]   rem_sh, diff;
`endif

    always_comb begin
        acc_d   = acc_q;
        sr_d    = sr_q;
        mul_sum = '0;
`ifdef MDU_DIV_EN
        rem_sh  = '0;
        diff    = '0;
`endif
        if (accept) begin
            acc_d = '0;
            sr_d  = is_div_in ? mag_a : mag_b;
        end else if (run) begin
            if (!is_div_q) begin
                // Shift-add: the add carry lands in bit WIDTH and is shifted
                // down into the upper product half.
                mul_sum = acc_q + (sr_q[0] ? {1'b0, opnd_q} : '0);
                acc_d   = {1'b0, mul_sum[WIDTH:1]};
                sr_d    = {mul_sum[0], sr_q[WIDTH-1:1]};
            end
`ifdef MDU_DIV_EN
            else begin
                // Restoring step. The remainder is always below the divisor,
                // so a non-negative difference never sets bit WIDTH and that
                // bit alone signals a borrow.
                rem_sh = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
                diff   = rem_sh - {1'b0, opnd_q};
                if (!diff[WIDTH]) begin
                    acc_d = diff;
                    sr_d  = {sr_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh;
                    sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                end
            end
`endif
        end
    end

    flopr #(.WIDTH(WIDTH+1)) u_acc (.clk(clk), .reset(reset), .d(acc_d), .q(acc_q));
    flopr #(.WIDTH(WIDTH))   u_sr  (.clk(clk), .reset(reset), .d(sr_d),  .q(sr_q));

    // ---------------- sign fix-up and HI/LO write (FIN) ----------------
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic               hilo_en;

    always_comb begin
        prod     = {acc_q[WIDTH-1:0], sr_q};
        prod_fix = neg_lo_q ? -prod : prod;
        hi_d     = prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div_q) begin
            lo_d = neg_lo_q ? -sr_q : sr_q;
            hi_d = neg_hi_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
        hilo_en = fin;
`else
        hilo_en = fin & ~is_div_q;
`endif
    end

    flopenr #(.WIDTH(WIDTH)) u_hi (.clk(clk), .reset(reset), .en(hilo_en), .d(hi_d), .q(hi));
    flopenr #(.WIDTH(WIDTH)) u_lo (.clk(clk), .reset(reset), .en(hilo_en), .d(lo_d), .q(lo));

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes the expected HI/LO and the
// cycle at which done must appear; a monitor pops and compares on done.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    mdu_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_err    = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive an op now; it is accepted at the next rising edge (E0).
    // Without the divider, DIV/DIVU must leave HI/LO at their prior values.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
`ifndef MDU_DIV_EN
        if (o[1]) begin
            eh = m_hi;
            el = m_lo;
        end
`endif
        m_hi  = eh;
        m_lo  = el;
        e.hi  = eh;
        e.lo  = el;
        e.cyc = cyc + MDU_LATENCY;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_checks++; n_err++;
            $display("FAIL wait_idle: got busy=1 after %0d cycles expected busy=0", k);
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++; n_err++;
            $display("FAIL wait_done: got done=0 after %0d cycles expected done=1", k);
        end
    endtask

    // Monitor: compares every done pulse against the scoreboard head.
    initial begin
        exp_t e;
        logic prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) check("done_one_cycle", {31'b0, done}, 32'd0);
            prev_done = done;
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending result", cyc);
                end else begin
                    e = sb.pop_front();
                    check("hi", hi, e.hi);
                    check("lo", lo, e.lo);
                    check("latency", W'(cyc), W'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 ns");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: unsigned full-scale product
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        check("busy_after_e0", {31'b0, busy}, 32'd1);
        wait_idle();

        // 2: signed products
        issue(MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        wait_idle();
        issue(MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        wait_idle();

        // 3: signed / unsigned divide
        issue(DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_idle();
        issue(DIVU, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
        wait_idle();

        // 4: signed overflow and divide by zero (raw dividend in HI)
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        wait_idle();
        issue(DIVU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
        wait_idle();
        issue(DIV, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        wait_idle();

        // 5: start mid-op is ignored; start in the done cycle is accepted
        issue(MULTU, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 32'hA3D7_0A38);
        repeat (10) @(negedge clk);
        start = 1'b1; op = DIV; a = 32'h0000_0001; b = 32'h0000_0001;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_mid_op", {31'b0, busy}, 32'd1);
        wait_done();
        issue(MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        wait_idle();

        // 6: reset mid-op aborts with no done pulse
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", {31'b0, busy}, 32'd0);

        issue(MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F);
        wait_idle();
        issue(DIV, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
        wait_idle();

        repeat (5) @(negedge clk);
        check("hold_hi", hi, m_hi);
        check("hold_lo", lo, m_lo);
        check("sb_drained", W'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
